// File: rtl/rr_arbiter_oh.sv
// Round-robin arbiter with packet locking; emits a one-hot select for a
// downstream one-hot mux and owns the requester/output valid-ready handshake.
module rr_arbiter_oh #(
  parameter int unsigned SEL_WIDTH = 4,
  parameter int unsigned IDX_WIDTH = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] req_valid_i,
  input  logic [SEL_WIDTH-1:0] req_last_i,
  output logic [SEL_WIDTH-1:0] req_ready_o,
  output logic [SEL_WIDTH-1:0] sel_oh_o,
  output logic [IDX_WIDTH-1:0] grant_idx_o,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]           state;
  logic [SEL_WIDTH-1:0] prio_oh;
  logic [SEL_WIDTH-1:0] lock_oh;
  logic [SEL_WIDTH-1:0] masked;
  logic [SEL_WIDTH-1:0] rr_pick;
  logic [SEL_WIDTH-1:0] grant;
  logic                 xfer_last;

  function automatic logic [SEL_WIDTH-1:0] rotl1(input logic [SEL_WIDTH-1:0] v);
    logic [SEL_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
      r[(i + 1) % SEL_WIDTH] = v[i];
    end
    return r;
  endfunction

  // Requests at or above the priority position win first; if none, the
  // lowest set request wins, which realises the wrap-around scan.
  always_comb begin
    masked  = req_valid_i & ~(prio_oh - SEL_WIDTH'(1));
    rr_pick = '0;
    if (|masked) begin
      rr_pick = masked & (~masked + SEL_WIDTH'(1));
    end else begin
      rr_pick = req_valid_i & (~req_valid_i + SEL_WIDTH'(1));
    end
    grant = '0;
    if (!rst) begin
      grant = (state == LOCK) ? lock_oh : rr_pick;
    end
  end

  always_comb begin
    grant_idx_o = '0;
    for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
      if (grant[i]) begin
        grant_idx_o = grant_idx_o | IDX_WIDTH'(i);
      end
    end
  end

  assign sel_oh_o    = grant;
  assign out_valid_o = |(req_valid_i & grant);
  assign out_last_o  = |(req_last_i & grant);
  assign req_ready_o = grant & {SEL_WIDTH{out_ready_i}};
  assign xfer_last   = out_valid_o && out_ready_i && out_last_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      prio_oh <= SEL_WIDTH'(1);
      lock_oh <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid_o && !(out_ready_i && out_last_o)) begin
            state   <= LOCK;
            lock_oh <= grant;
          end
        end
        LOCK: begin
          if (xfer_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (xfer_last) begin
        prio_oh <= rotl1(grant);
      end
    end
  end

`ifdef COMM_ASSERT
  a_sel_onehot0: assert property (@(posedge clk) $onehot0(sel_oh_o));
  a_prio_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(prio_oh));
  a_lock_stable: assert property (@(posedge clk) disable iff (rst)
    (state == LOCK) |=> (rst || state != LOCK || $stable(sel_oh_o)));
`endif

endmodule
